// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone engine.
//   NOTE_MAX  : highest pitched note id (1..NOTE_MAX are tones, everything else is a rest)
//   FREQ_HZ   : pitch of note ids 1..NOTE_MAX, three octaves C4..B6
//   state_t   : tone engine sequencing states
//   period_of : elaboration-time sys_clk cycles per pitch period (1 ms for rests)
package buzzer_pkg;

    localparam int unsigned NOTE_MAX = 21;

    localparam int unsigned FREQ_HZ [NOTE_MAX] = '{
        262,  294,  330,  349,  392,  440,  494,
        523,  587,  659,  698,  784,  880,  988,
        1047, 1175, 1319, 1397, 1568, 1760, 1976
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Rests reuse the 1 ms divider as their period; their duty is forced to
    // zero elsewhere, so the value only has to be a legal non-zero period.
    function automatic int unsigned period_of(input int unsigned id,
                                              input int unsigned clk_hz);
        if (id >= 1 && id <= NOTE_MAX)
            return clk_hz / FREQ_HZ[5'(id - 1)];
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/buzzer_tone_gen_ms_ticker.sv
// Millisecond strobe generator shared by the PLAY and GAP timers.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   clr       : restart the millisecond (first tick DIV enabled cycles later)
//   en        : count enable
//   tick      : high on the last enabled cycle of every DIV-cycle millisecond
module ms_ticker #(
    parameter int unsigned DIV = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= W'(DIV - 1);
        else if (en)
            cnt <= (cnt == '0) ? W'(DIV - 1) : cnt - 1'b1;
    end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Tone engine for a passive buzzer: takes one note (id, duty, length in ms)
// over valid/ready, plays a square wave of the note's pitch for the length,
// then holds a silent articulation gap of GAP_MS before returning to idle.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   note_valid/ready   : note handshake (ready only in IDLE and without abort)
//   note_id/duty/len   : pitch id (0/22..31 rest), high time in 1/16 period, ms
//   abort              : synchronous stop without done
//   beep               : registered buzzer drive
//   busy               : engine not idle
//   done               : one-cycle pulse after a note and its gap complete
//
// state | meaning
// IDLE  | waiting for a note, note_ready high unless abort
// PLAY  | square wave of the latched period/threshold for note_len ms
// GAP   | silent articulation gap of GAP_MS ms
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned CNT_W  = 22,
    parameter int unsigned LEN_W  = 12,
    parameter int unsigned GAP_MS = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [4:0]       note_id,
    input  logic [3:0]       note_duty,
    input  logic [LEN_W-1:0] note_len,
    input  logic             abort,
    output logic             beep,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      MS_DIV  = CLK_HZ / 1000;
    localparam logic [LEN_W-1:0] GAP_LEN = LEN_W'(GAP_MS);

    state_t           state;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] thresh;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_nxt;
    logic [LEN_W-1:0] ms_left;

    logic [CNT_W-1:0] period_rom [32];
    logic [CNT_W-1:0] period_sel;
    logic [CNT_W-1:0] thresh_sel;
    logic [CNT_W+3:0] duty_prod;
    logic             is_rest;
    logic             accept;
    logic             ms_tick;
    logic             ms_last;
    logic             play_end;

    for (genvar i = 0; i < 32; i++) begin : g_period_rom
        assign period_rom[i] = CNT_W'(period_of(i, CLK_HZ));
    end

    assign is_rest    = (note_id == 5'd0) || (note_id > 5'(NOTE_MAX));
    assign period_sel = period_rom[note_id];
    assign duty_prod  = (CNT_W+4)'(period_sel) * (CNT_W+4)'(note_duty);
    assign thresh_sel = is_rest ? '0 : CNT_W'(duty_prod >> 4);

    assign note_ready = (state == IDLE) && !abort;
    assign accept     = note_valid && note_ready;
    assign busy       = (state != IDLE);

    assign ms_last  = (ms_left == LEN_W'(1));
    assign play_end = (state == PLAY) && ms_tick && ms_last;
    // pcnt is the index of the current cycle within the period; beep is
    // registered, so it is loaded with the level for the following index.
    assign pcnt_nxt = (pcnt == period - 1'b1) ? '0 : pcnt + 1'b1;

    ms_ticker #(
        .DIV (MS_DIV)
    ) u_ms_ticker (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       ((state == IDLE) || play_end),
        .en        (state != IDLE),
        .tick      (ms_tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            period  <= '0;
            thresh  <= '0;
            pcnt    <= '0;
            ms_left <= '0;
            beep    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                beep  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            period <= period_sel;
                            thresh <= thresh_sel;
                            pcnt   <= '0;
                            if (note_len == '0) begin
                                beep <= 1'b0;
                                if (GAP_MS == 0) begin
                                    done <= 1'b1;
                                end else begin
                                    state   <= GAP;
                                    ms_left <= GAP_LEN;
                                end
                            end else begin
                                state   <= PLAY;
                                ms_left <= note_len;
                                beep    <= (thresh_sel != '0);
                            end
                        end
                    end
                    PLAY: begin
                        pcnt <= pcnt_nxt;
                        beep <= (pcnt_nxt < thresh);
                        if (ms_tick) begin
                            if (ms_last) begin
                                beep <= 1'b0;
                                if (GAP_MS == 0) begin
                                    state <= IDLE;
                                    done  <= 1'b1;
                                end else begin
                                    state   <= GAP;
                                    ms_left <= GAP_LEN;
                                end
                            end else begin
                                ms_left <= ms_left - 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        beep <= 1'b0;
                        if (ms_tick) begin
                            if (ms_last) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                ms_left <= ms_left - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        beep  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
module tb_buzzer_tone_gen;

    localparam int CLK = 1_000_000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        note_valid, note_valid0;
    logic [4:0]  note_id;
    logic [3:0]  note_duty;
    logic [11:0] note_len;
    logic        abort;
    logic        ready1, beep1, busy1, done1;
    logic        ready0, beep0, busy0, done0;

    int checks = 0;
    int errors = 0;
    bit use0   = 1'b0;

    int FREQ [21] = '{262, 294, 330, 349, 392, 440, 494,
                      523, 587, 659, 698, 784, 880, 988,
                      1047, 1175, 1319, 1397, 1568, 1760, 1976};

    logic ready_s, beep_s, busy_s, done_s;
    assign ready_s = use0 ? ready0 : ready1;
    assign beep_s  = use0 ? beep0  : beep1;
    assign busy_s  = use0 ? busy0  : busy1;
    assign done_s  = use0 ? done0  : done1;

    always #5 sys_clk = ~sys_clk;

    buzzer_tone_gen #(.CLK_HZ(CLK), .CNT_W(22), .LEN_W(12), .GAP_MS(1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .note_valid(note_valid),
        .note_ready(ready1), .note_id(note_id), .note_duty(note_duty),
        .note_len(note_len), .abort(abort), .beep(beep1), .busy(busy1), .done(done1));

    buzzer_tone_gen #(.CLK_HZ(CLK), .CNT_W(22), .LEN_W(12), .GAP_MS(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .note_valid(note_valid0),
        .note_ready(ready0), .note_id(note_id), .note_duty(note_duty),
        .note_len(note_len), .abort(abort), .beep(beep0), .busy(busy0), .done(done0));

    function automatic int ref_period(input int id);
        if (id >= 1 && id <= 21) return CLK / FREQ[id-1];
        return CLK / 1000;
    endfunction

    function automatic int ref_thresh(input int id, input int duty);
        if (id >= 1 && id <= 21) return (ref_period(id) * duty) / 16;
        return 0;
    endfunction

    // Called at a negedge with the selected DUT idle; returns at the negedge
    // of the done cycle so a following call accepts back-to-back.
    task automatic run_note(input bit sel0, input int id, input int duty, input int len,
                            input string name);
        int per, thr, play, total;
        int beep_err, busy_err, highs, exp_highs, done_at;
        bit exp_b;
        use0  = sel0;
        per   = ref_period(id);
        thr   = ref_thresh(id, duty);
        play  = len * 1000;
        total = play + (sel0 ? 0 : 1000);
        #1;
        checks++;
        if (ready_s !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got=%b want=1", name, ready_s);
        end
        note_id   = 5'(id);
        note_duty = 4'(duty);
        note_len  = 12'(len);
        if (sel0) note_valid0 = 1'b1; else note_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        note_valid  = 1'b0;
        note_valid0 = 1'b0;
        beep_err = 0; busy_err = 0; highs = 0; exp_highs = 0; done_at = -1;
        for (int k = 0; k <= total; k++) begin
            if (k > 0) @(negedge sys_clk);
            exp_b = (k < play) && ((k % per) < thr);
            if (beep_s !== exp_b) beep_err++;
            if (beep_s === 1'b1) highs++;
            if (exp_b) exp_highs++;
            if (busy_s !== (k < total)) busy_err++;
            if (done_s === 1'b1 && done_at < 0) done_at = k;
        end
        checks++;
        if (beep_err != 0) begin
            errors++;
            $display("FAIL %s beep_pattern mismatched_cycles=%0d want=0", name, beep_err);
        end
        checks++;
        if (highs != exp_highs) begin
            errors++;
            $display("FAIL %s beep_high_cycles got=%0d want=%0d", name, highs, exp_highs);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL %s busy_window mismatched_cycles=%0d want=0", name, busy_err);
        end
        checks++;
        if (done_at != total) begin
            errors++;
            $display("FAIL %s done_cycle got=%0d want=%0d", name, done_at, total);
        end
        checks++;
        if (ready_s !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_in_done_cycle got=%b want=1", name, ready_s);
        end
    endtask

    task automatic test_reset;
        use0 = 1'b0;
        #1;
        checks++;
        if ({beep1, busy1, done1, ready1, beep0, busy0, done0, ready0} !== 8'b0001_0001) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=00010001",
                     {beep1, busy1, done1, ready1, beep0, busy0, done0, ready0});
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({beep1, busy1, done1, ready1} !== 4'b0001) begin
            errors++;
            $display("FAIL after_release got=%b want=0001", {beep1, busy1, done1, ready1});
        end
    endtask

    task automatic test_basic;
        run_note(1'b0, 8, 8, 3, "mid_c_half_duty");
    endtask

    task automatic test_rest;
        run_note(1'b0, 0, 15, 2, "rest_id0");
        run_note(1'b0, 27, 15, 2, "rest_id27");
    endtask

    task automatic test_duty;
        run_note(1'b0, 21, 0, 1, "duty0_id21");
        run_note(1'b0, 21, 15, 1, "duty15_id21");
    endtask

    task automatic test_len0;
        run_note(1'b0, 10, 8, 0, "len0_gap1");
        run_note(1'b1, 10, 8, 0, "len0_gap0");
        run_note(1'b1, 3, 4, 1, "gap0_note");
        use0 = 1'b0;
    endtask

    task automatic test_abort;
        int per, thr, err;
        use0 = 1'b0;
        per = ref_period(5);
        thr = ref_thresh(5, 8);
        err = 0;
        note_id = 5'd5; note_duty = 4'd8; note_len = 12'd3;
        note_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        // valid stays high with a different note: it must be ignored while busy
        note_id = 5'd21; note_duty = 4'd15; note_len = 12'd1;
        for (int k = 0; k <= 500; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (beep1 !== ((k % per) < thr)) err++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || ready1 !== 1'b0) err++;
        end
        checks++;
        if (err != 0) begin
            errors++;
            $display("FAIL abort_pre_play mismatched_cycles=%0d want=0", err);
        end
        abort = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({beep1, busy1, done1, ready1} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_next_edge got=%b want=0000", {beep1, busy1, done1, ready1});
        end
        abort = 1'b0;
        #1;
        checks++;
        if ({busy1, done1, ready1} !== 3'b001) begin
            errors++;
            $display("FAIL abort_release got=%b want=001", {busy1, done1, ready1});
        end
        @(negedge sys_clk);
        checks++;
        if ({beep1, busy1, done1} !== 3'b110) begin
            errors++;
            $display("FAIL held_valid_accept got=%b want=110", {beep1, busy1, done1});
        end
        note_valid = 1'b0;
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({busy1, done1} !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_done got=%b want=00", {busy1, done1});
        end
    endtask

    task automatic test_reset_mid;
        use0 = 1'b0;
        note_id = 5'd8; note_duty = 4'd8; note_len = 12'd3;
        note_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        note_valid = 1'b0;
        repeat (300) @(negedge sys_clk);
        checks++;
        if ({beep1, busy1} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_playing got=%b want=11", {beep1, busy1});
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({beep1, busy1, done1, ready1} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset_outputs got=%b want=0001", {beep1, busy1, done1, ready1});
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        note_id = 5'd1; note_duty = 4'd8; note_len = 12'd1;
        note_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        note_valid = 1'b0;
        checks++;
        if ({beep1, busy1, done1} !== 3'b110) begin
            errors++;
            $display("FAIL accept_after_reset got=%b want=110", {beep1, busy1, done1});
        end
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back;
        int id, duty, len;
        for (int n = 0; n < 6; n++) begin
            id   = int'($urandom_range(31));
            duty = int'($urandom_range(15));
            len  = int'($urandom_range(2));
            run_note(1'b0, id, duty, len, $sformatf("rand%0d_id%0d_d%0d_l%0d", n, id, duty, len));
        end
        @(negedge sys_clk);
        checks++;
        if ({busy1, done1} !== 2'b00) begin
            errors++;
            $display("FAIL done_single_cycle got=%b want=00", {busy1, done1});
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n   = 1'b0;
        note_valid  = 1'b0;
        note_valid0 = 1'b0;
        note_id     = '0;
        note_duty   = '0;
        note_len    = '0;
        abort       = 1'b0;
        repeat (3) @(negedge sys_clk);
        test_reset;
        test_basic;
        test_rest;
        test_duty;
        test_len0;
        @(negedge sys_clk);
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_gen.md
# buzzer_tone_gen

Parametrised tone engine for the passive-buzzer projects: accepts one note at a time (note id, duty, duration) over a valid/ready handshake and drives a square wave of the note's pitch for the requested number of milliseconds, followed by a fixed silent articulation gap. Supersedes the fixed-table, fixed-clock note-to-period lookup. It generalises that lookup to three octaves, any clock frequency and programmable duty, and adds the period counter, duration timing and sequencing. It sits between the score/melody ROM sequencer and the buzzer pin.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz; all periods and ms ticks derive from it
- CNT_W, 22, period/duty counter width; must hold CLK_HZ/262
- LEN_W, 12, note duration width, in ms
- GAP_MS, 10, silent gap after every note, in ms; 0 = no gap
- sys_clk  in  1  system clock; the single clock domain
- sys_rst_n  in  1  asynchronous, active-low reset
- note_valid  in  1  note request
- note_ready  out  1  high only in IDLE; a note is accepted on a sys_clk edge with note_valid && note_ready
- note_id  in  5  0 = rest; 1–7 low C4–B4; 8–14 mid C5–B5; 15–21 high C6–B6; 22–31 = rest
- note_duty  in  4  high time in sixteenths of the period; 0 = silent
- note_len  in  LEN_W  duration in ms
- abort  in  1  synchronous stop; wins over everything except reset
- beep  out  1  registered buzzer drive
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a note (including its gap) completes normally

## Operation
- Frequency table, in Hz: 262, 294, 330, 349, 392, 440, 494 / 523, 587, 659, 698, 784, 880, 988 / 1047, 1175, 1319, 1397, 1568, 1760, 1976.
- period = CLK_HZ / f, truncated and evaluated at elaboration. At 50 MHz: id1 = 190839, id5 = 127551, id8 = 95602, id12 = 63775, id15 = 47755, id21 = 25303.
- On accept, the block latches:
  - period
  - thresh = (period × note_duty) >> 4, computed at CNT_W+4 bits then truncated
  - note_len
- For a rest id, thresh = 0 and period = MS_DIV. The timing is identical to a tone; beep stays 0.
- MS_DIV = CLK_HZ / 1000. The ms tick counter restarts at 0 on accept and on entering GAP.
- States:
  - IDLE: on accept → PLAY, or → GAP if note_len == 0.
  - PLAY: cnt runs 0..period−1 and wraps; beep = (cnt < thresh). After note_len × MS_DIV cycles → GAP, or → IDLE with done if GAP_MS == 0.
  - GAP: beep = 0. After GAP_MS × MS_DIV cycles → IDLE with done.
- abort in any non-IDLE state: → IDLE next edge, beep = 0, no done. abort in IDLE has no effect, and an accept in that same cycle is blocked (note_ready is forced low while abort is high).
- note_valid while busy is ignored; no queueing.

## Timing
- Reset values:
  - state IDLE
  - beep 0, done 0, busy 0
  - note_ready 1 (deasserts while abort is high)
  - all counters 0
- Accept at edge E0. From E0 onward: busy = 1, note_ready = 0, and beep = (thresh != 0) in the first PLAY cycle. This gives zero latency from accept to the first beep level.
- beep is high for exactly thresh cycles of every period cycles. The last partial period is cut at the duration boundary.
- PLAY occupies exactly note_len × MS_DIV cycles; GAP occupies exactly GAP_MS × MS_DIV cycles.
- done is high for the single cycle following the last GAP cycle. In that same cycle note_ready = 1, so back-to-back notes lose no cycles.
- Asynchronous reset mid-note: all outputs go to their reset values immediately, with no done.

## Structure
- Package buzzer_pkg holds:
  - NOTE_MAX = 21
  - the Hz frequency table
  - the state enum {IDLE, PLAY, GAP}
  - the elaboration-time function period_of(id, clk_hz)
- One sub-module, ms_ticker (parameter DIV; inputs clr and en; output tick): it generates the 1 ms strobe used by both the PLAY and GAP timers.

## Test plan
- CLK_HZ = 1_000_000, id 8, duty 8, len 3, GAP_MS = 1 → period 1912, beep high 956 / low 956 cycles, PLAY 3000 cycles, GAP 1000 cycles, done at cycle 4000.
- id 0, then id 27, each with duty 15, len 2 → beep constantly 0, busy 3000 cycles, done pulses.
- duty 0 and duty 15 on id 21 (period 506 at 1 MHz) → beep never high; then exactly 474 high / 32 low per period.
- note_len 0, GAP_MS = 1 → no PLAY, 1000 GAP cycles, done; with GAP_MS = 0 → done on the cycle after accept.
- abort at cycle 500 of PLAY → beep 0 and IDLE on the next edge, no done; note_valid held high during busy is not accepted until IDLE.
- sys_rst_n pulsed low mid-PLAY → beep, busy and done all 0 immediately, note_ready 1; a new note is accepted on the first edge after release.
